// File: rtl/sliding_pattern_detector_pkg.sv
// Shared types and constants for the sliding pattern detector.
// SWD_HIT_COUNT_EN (see top) enables the per-channel hit counters.
package swd_pkg;

    typedef enum logic {
        SWD_OVERLAP    = 1'b0,
        SWD_NONOVERLAP = 1'b1
    } swd_mode_e;

    localparam int unsigned SWD_HIT_W   = 8;
    localparam int unsigned SWD_HIT_MAX = 255;

endpackage

// File: rtl/sliding_pattern_detector_if.sv
// Bit-stream, configuration and result signals of the sliding pattern detector.
// master drives stimulus and configuration; slave is the detector side.
interface sliding_pattern_detector_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CH = 2
);
    localparam int unsigned SelW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned CntW = $clog2(W + 1);

    logic                in_valid;
    logic                in_bit;
    logic                cfg_we;
    logic [SelW-1:0]     cfg_sel;
    logic [W-1:0]        cfg_pat;
    logic [W-1:0]        cfg_mask;
    logic                cfg_mode;
    logic [CH-1:0]       dec;
    logic [CntW-1:0]     ones_cnt;
    logic [8*CH-1:0]     hit_cnt;

    modport master (
        output in_valid, in_bit, cfg_we, cfg_sel, cfg_pat, cfg_mask, cfg_mode,
        input  dec, ones_cnt, hit_cnt
    );

    modport slave (
        input  in_valid, in_bit, cfg_we, cfg_sel, cfg_pat, cfg_mask, cfg_mode,
        output dec, ones_cnt, hit_cnt
    );
endinterface

// File: rtl/sliding_pattern_detector_channel.sv
// One pattern channel: holds its pattern/mask/mode, non-overlap holdoff and hit counter.
// The hit counter exists only when SWD_HIT_COUNT_EN is defined.
module swd_channel
    import swd_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         next_win_i,
    input  logic                 win_full_i,
    input  logic                 in_valid_i,
    input  logic                 cfg_we_i,
    input  logic [W-1:0]         cfg_pat_i,
    input  logic [W-1:0]         cfg_mask_i,
    input  swd_mode_e            cfg_mode_i,
    output logic                 dec_o,
    output logic [SWD_HIT_W-1:0] hit_cnt_o
);
    localparam int unsigned HoldW = $clog2(W);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(W - 1);

    logic [W-1:0]     pat_q, pat_d, mask_q, mask_d;
    swd_mode_e        mode_q, mode_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             dec_q, dec_d;
    logic             match;

    // Match always uses the stored config, so a same-cycle write only affects later bits.
    assign match = in_valid_i && win_full_i && (((next_win_i ^ pat_q) & mask_q) == '0)
                   && (hold_q == '0);

    always_comb begin
        pat_d  = pat_q;
        mask_d = mask_q;
        mode_d = mode_q;
        hold_d = hold_q;
        dec_d  = match;
        if (cfg_we_i) begin
            pat_d  = cfg_pat_i;
            mask_d = cfg_mask_i;
            mode_d = cfg_mode_i;
            hold_d = '0;
        end else if (in_valid_i) begin
            if (match && (mode_q == SWD_NONOVERLAP)) begin
                hold_d = HoldLoad;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            mask_q <= '0;
            mode_q <= SWD_OVERLAP;
            hold_q <= '0;
            dec_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            hold_q <= hold_d;
            dec_q  <= dec_d;
        end
    end

    assign dec_o = dec_q;

`ifdef SWD_HIT_COUNT_EN
    logic [SWD_HIT_W-1:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (cfg_we_i) begin
            hit_d = '0;
        end else if (match && (hit_q != SWD_HIT_W'(SWD_HIT_MAX))) begin
            hit_d = hit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt_o = hit_q;
`else
    assign hit_cnt_o = '0;
`endif

endmodule

// File: rtl/sliding_pattern_detector.sv
// Serial W-bit sliding window with CH maskable pattern channels and a running popcount.
// Define SWD_HIT_COUNT_EN to build the per-channel 8-bit hit counters.
module sliding_pattern_detector
    import swd_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned CH = 2
) (
    input logic                  clk,
    input logic                  rst,
    sliding_pattern_detector_if.slave bus
);
    localparam int unsigned SelW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] FillMax = CntW'(W);

    logic [W-1:0]              win_q, win_d, next_win;
    logic [CntW-1:0]           fill_q, fill_d, ones_q, ones_d;
    logic                      win_full;
    logic [CH-1:0]             cfg_we_w, dec_w;
    logic [SWD_HIT_W*CH-1:0]   hit_w;

    always_comb begin
        next_win = {win_q[W-2:0], bus.in_bit};
        win_d    = win_q;
        fill_d   = fill_q;
        ones_d   = ones_q;
        if (bus.in_valid) begin
            win_d = next_win;
            if (fill_q != FillMax) begin
                fill_d = fill_q + 1'b1;
            end
            // Running popcount: add the new bit, drop the one falling off the MSB.
            ones_d = ones_q + CntW'(bus.in_bit) - CntW'(win_q[W-1]);
        end
    end

    assign win_full = (fill_d == FillMax);

    always_comb begin
        cfg_we_w = '0;
        for (int c = 0; c < CH; c++) begin
            cfg_we_w[c] = bus.cfg_we && (bus.cfg_sel == SelW'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
            ones_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            ones_q <= ones_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        swd_channel #(
            .W(W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .next_win_i (next_win),
            .win_full_i (win_full),
            .in_valid_i (bus.in_valid),
            .cfg_we_i   (cfg_we_w[c]),
            .cfg_pat_i  (bus.cfg_pat),
            .cfg_mask_i (bus.cfg_mask),
            .cfg_mode_i (swd_mode_e'(bus.cfg_mode)),
            .dec_o      (dec_w[c]),
            .hit_cnt_o  (hit_w[SWD_HIT_W*c +: SWD_HIT_W])
        );
    end

    assign bus.dec      = dec_w;
    assign bus.ones_cnt = ones_q;
    assign bus.hit_cnt  = hit_w;

endmodule

// File: doc/sliding_pattern_detector.md
# sliding_pattern_detector

Parametrised serial-bitstream detector that shifts a 1-bit input into a W-bit sliding window and compares it against CH independently programmable, maskable patterns. Each channel runs in overlapping or non-overlapping mode and pulses its own detect line. A running popcount of the window is also provided. The block sits directly behind the serial input stage and generalises the fixed two-output window detector to arbitrary width, channel count and per-channel mode.

## Interface
- W, default 4: window length in bits, legal range 2..32.
- CH, default 2: number of pattern channels, legal range 1..8.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_bit. The window shifts only when this is high.
- in_bit  in  1  serial data bit.
- cfg_we  in  1  write strobe for one channel's configuration.
- cfg_sel  in  $clog2(CH) (min 1)  channel index for the write. Out-of-range indices are ignored.
- cfg_pat  in  W  pattern. Bit 0 is compared against the newest bit.
- cfg_mask  in  W  compare mask. A 1 means the bit is compared; a 0 means don't-care.
- cfg_mode  in  1  0 = OVERLAP, 1 = NONOVERLAP.
- dec  out  CH  per-channel one-cycle detect pulse.
- ones_cnt  out  $clog2(W+1)  number of 1s in the current window.
- hit_cnt  out  8*CH  per-channel hit counters, with channel c at [8c+7:8c].

## Operation
- Window update on each edge with in_valid=1: win <= {win[W-2:0], in_bit}. The newest bit is at LSB.
- Fill counter:
  - Counts valid bits and saturates at W.
  - No channel may detect until the updated fill reaches W, i.e. not before the W-th bit after reset.
- Channel c matches when all of the following hold:
  - in_valid=1.
  - Fill is full after the update.
  - ((next_win ^ pat[c]) & mask[c]) == 0.
  - holdoff[c] == 0.
- A mask of all zeros matches every valid bit once the window is full.
- OVERLAP mode: every matching bit produces a pulse.
- NONOVERLAP mode: a hit loads holdoff[c] = W-1. Each later valid bit decrements holdoff and suppresses detection while holdoff is non-zero. The net effect is that the next hit needs W fresh bits.
- ones_cnt is the registered popcount of the window and updates on the same edge as the window.
- cfg_we write:
  - Loads pat, mask and mode for channel cfg_sel.
  - Clears that channel's holdoff and hit counter.
  - Does not touch the window or fill counter.
  - The write takes effect at the edge it is sampled on. A bit arriving in the same cycle is compared against the old configuration.
- Reset values: window 0, fill 0, all pat 0, all mask 0, all mode OVERLAP, holdoff 0, dec 0, ones_cnt 0, hit_cnt 0.
- Reset asserted mid-stream clears everything immediately (asynchronously), and a new fill period is required afterwards.

## Timing
- dec[c] is registered. It rises on the edge that samples the completing bit and stays high for exactly one cycle.
- dec is never asserted on a cycle following in_valid=0, so idle gaps hold the window and produce no repeat pulses.
- ones_cnt has the same latency as dec, one edge after the bit.
- Back-to-back valid bits are accepted every cycle. There is no backpressure.

## Configuration
- SWD_HIT_COUNT_EN
  - Defined: each channel has an 8-bit hit counter that increments on every dec pulse and saturates at 255. It is cleared by rst or by a cfg write to that channel.
  - Undefined: no counter logic is built and hit_cnt is driven to constant 0. The port list is unchanged.

## Structure
- Shared package swd_pkg holds:
  - typedef swd_mode_e with values SWD_OVERLAP=0 and SWD_NONOVERLAP=1.
  - localparam SWD_HIT_W = 8.
  - localparam SWD_HIT_MAX = 255.
- Sub-module swd_channel, instantiated CH times via generate. It owns pat, mask, mode, holdoff, its dec bit and its hit counter. Its inputs are next_win, the window-full flag, in_valid, and its decoded write strobe.
- The top level owns the window, the fill counter, the popcount and the cfg decode.

## Test plan
All scenarios use W=4 and CH=2 with SWD_HIT_COUNT_EN defined.
- Reset: pulse rst asynchronously between clock edges. Required: dec=0, ones_cnt=0 and hit_cnt=0 immediately.
- Overlap: ch0 pat=1011, mask=1111, OVERLAP. Feed 1,0,1,1,0,1,1. Required: dec[0] pulses after bits 4 and 7 only, and hit_cnt[7:0]=2.
- Non-overlap: ch1 pat=1111, mask=1111, NONOVERLAP. Feed eight 1s. Required: dec[1] pulses after bits 4 and 8. The same stimulus in OVERLAP mode must give pulses after bits 4 through 8 (5 pulses).
- Fill gating and gaps: ch0 pat=0000, mask=1111 after reset. Feed 3 zeros, then hold in_valid=0 for 5 cycles, then feed 1 zero. Required: no dec during the first 3 bits or the gap, one dec[0] pulse after the 4th bit, and ones_cnt=0 throughout.
- Mask and config write: ch0 mask=0000. After the window is full, every valid bit pulses dec[0]. A cfg write to ch0 in the same cycle as a valid bit must still use the old configuration for that bit, and hit_cnt ch0 reads 0 on the next cycle.
- Saturation and mid-reset: with mask=0000, feed 300 bits. Required: hit_cnt ch0 = 255. Then assert rst mid-stream. Required: all outputs are 0 and no dec occurs until 4 new bits have been fed.
